pkt_tx_assembler: RTL and testbench

- Transmit-side counterpart of the node-info receiver. It builds outgoing protocol packets (HB, CHE, INV, MR, DATA) from the node's own state and serializes them as 16-bit words over a valid/ready stream to the radio/MAC interface.
- Energy fields use Q2.14 fixed point: 16'h4000 = 1.0.
- It sits between the node-info/Q-learning logic and the transmitter FIFO.

---
 rtl/pkt_tx_assembler_pkg.sv | 40 ++++
 rtl/pkt_checksum_acc.sv | 26 ++
 rtl/pkt_tx_assembler.sv | 200 ++++++++++++++++++++
 tb/tb_pkt_tx_assembler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pkt_tx_assembler_pkg.sv
// Shared definitions for the packet transmit assembler: type codes, payload
// lengths, FSM state encoding and Q2.14 constants.
package pkt_tx_assembler_pkg;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_INV  = 3'b010;
  localparam logic [2:0] PKT_MR   = 3'b011;
  localparam logic [2:0] PKT_DATA = 3'b100;

  localparam logic [2:0] LEN_HB   = 3'd4;
  localparam logic [2:0] LEN_CHE  = 3'd2;
  localparam logic [2:0] LEN_INV  = 3'd3;
  localparam logic [2:0] LEN_MR   = 3'd3;
  localparam logic [2:0] LEN_DATA = 3'd4;

  localparam logic [15:0] Q_ONE  = 16'h4000;
  localparam logic [15:0] Q_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SRC,
    ST_PAY,
    ST_DONE
  } tx_state_e;

  // Payload word count (excluding any trailer); 0 for invalid types.
  function automatic logic [2:0] pkt_len(input logic [2:0] t);
    case (t)
      PKT_HB:   pkt_len = LEN_HB;
      PKT_CHE:  pkt_len = LEN_CHE;
      PKT_INV:  pkt_len = LEN_INV;
      PKT_MR:   pkt_len = LEN_MR;
      PKT_DATA: pkt_len = LEN_DATA;
      default:  pkt_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pkt_checksum_acc.sv
// Running 16-bit wrap-around sum of accepted packet words (trailer source
// when PKT_CHECKSUM_EN is defined).
module pkt_checksum_acc (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] r_sum;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (add) begin
      r_sum <= r_sum + word;
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/pkt_tx_assembler.sv
// Builds HB/CHE/INV/MR/DATA packets and streams them as 16-bit words over
// valid/ready. Optional trailer checksum enabled by defining PKT_CHECKSUM_EN.
module pkt_tx_assembler
  import pkt_tx_assembler_pkg::*;
#(
  parameter logic [15:0] MAX_HOPS = 16'hFFFF,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en_TX,
  input  logic [2:0]  txPktType,
  input  logic [15:0] myNodeID,
  input  logic [15:0] hopsFromSink,
  input  logic [15:0] myQValue,
  input  logic [15:0] energy,
  input  logic [15:0] e_max,
  input  logic [15:0] e_min,
  input  logic [15:0] e_threshold,
  input  logic [15:0] ch_ID,
  input  logic [15:0] timeslot,
  input  logic [15:0] data_in,
  input  logic        tx_ready,
  output logic [15:0] tx_word,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  tx_state_e   r_state;
  tx_state_e   w_next;

  logic [2:0]  r_type;
  logic [2:0]  r_plen;
  logic [2:0]  r_idx;
  logic [15:0] r_src;
  logic [15:0] r_pay [4];
  logic        r_err;

  logic        w_start;
  logic        w_bad;
  logic        w_accept;
  logic [16:0] w_hop17;
  logic [15:0] w_hop;
  logic [15:0] w_pay [4];
  logic [7:0]  w_hdr_len;
  logic [2:0]  w_last_idx;
  logic [15:0] w_hdr;
  logic [15:0] w_pay_word;

  assign w_start = en_TX && (r_state == ST_IDLE) && (txPktType <= PKT_DATA);
  assign w_bad   = en_TX && (r_state == ST_IDLE) && (txPktType >  PKT_DATA);

  assign w_hop17 = {1'b0, hopsFromSink} + 17'd1;
  assign w_hop   = (w_hop17 > {1'b0, MAX_HOPS}) ? MAX_HOPS : w_hop17[15:0];

  always_comb begin
    w_pay[0] = '0;
    w_pay[1] = '0;
    w_pay[2] = '0;
    w_pay[3] = '0;
    case (txPktType)
      PKT_HB: begin
        w_pay[0] = w_hop;
        w_pay[1] = e_max;
        w_pay[2] = e_min;
        w_pay[3] = e_threshold;
      end
      PKT_CHE: begin
        w_pay[0] = ch_ID;
        w_pay[1] = myQValue;
      end
      PKT_INV: begin
        w_pay[0] = hopsFromSink;
        w_pay[1] = myQValue;
        w_pay[2] = timeslot;
      end
      PKT_MR: begin
        w_pay[0] = ch_ID;
        w_pay[1] = energy;
        w_pay[2] = myQValue;
      end
      PKT_DATA: begin
        w_pay[0] = ch_ID;
        w_pay[1] = timeslot;
        w_pay[2] = energy;
        w_pay[3] = data_in;
      end
      default: ;
    endcase
  end

`ifdef PKT_CHECKSUM_EN
  logic [15:0] w_sum;

  // Trailer sits at index r_plen, one past the last payload word.
  assign w_hdr_len  = {5'd0, r_plen} + 8'd1;
  assign w_last_idx = r_plen;
  assign w_pay_word = (r_idx == r_plen) ? w_sum : r_pay[r_idx[1:0]];

  pkt_checksum_acc u_csum (
    .clk   (clk),
    .nrst  (nrst),
    .clear (w_start),
    .add   (w_accept),
    .word  (tx_word),
    .sum   (w_sum)
  );
`else
  assign w_hdr_len  = {5'd0, r_plen};
  assign w_last_idx = r_plen - 3'd1;
  assign w_pay_word = r_pay[r_idx[1:0]];
`endif

  assign w_hdr = {r_type, PAD_BYTE[4:0], w_hdr_len};

  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_word  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_HDR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_word  = w_hdr;
      end
      ST_SRC: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_word  = r_src;
      end
      ST_PAY: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_word  = w_pay_word;
        tx_last  = (r_idx == w_last_idx);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = tx_valid && tx_ready;
  assign err      = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start)              w_next = ST_HDR;
      ST_HDR:  if (w_accept)             w_next = ST_SRC;
      ST_SRC:  if (w_accept)             w_next = ST_PAY;
      ST_PAY:  if (w_accept && tx_last)  w_next = ST_DONE;
      ST_DONE:                           w_next = ST_IDLE;
      default:                           w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_type  <= '0;
      r_plen  <= '0;
      r_src   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_pay[0] <= '0;
      r_pay[1] <= '0;
      r_pay[2] <= '0;
      r_pay[3] <= '0;
    end else begin
      r_err <= w_bad;
      if (w_start) begin
        r_type   <= txPktType;
        r_plen   <= pkt_len(txPktType);
        r_src    <= myNodeID;
        r_pay[0] <= w_pay[0];
        r_pay[1] <= w_pay[1];
        r_pay[2] <= w_pay[2];
        r_pay[3] <= w_pay[3];
      end
      if (r_state == ST_HDR) begin
        r_idx <= '0;
      end else if (r_state == ST_PAY && w_accept) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_tx_assembler.sv
// Directed self-checking bench for pkt_tx_assembler; expected words are
// hand-computed, with the checksum trailer appended when PKT_CHECKSUM_EN is set.
module tb_pkt_tx_assembler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en_TX;
  logic [2:0]  txPktType;
  logic [15:0] myNodeID, hopsFromSink, myQValue, energy;
  logic [15:0] e_max, e_min, e_threshold, ch_ID, timeslot, data_in;
  logic        tx_ready;
  logic [15:0] tx_word;
  logic        tx_valid, tx_last, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  int          last_pos;
  bit          done_seen;
  int          hold_bad;

  always #5 clk = ~clk;

  pkt_tx_assembler #(
    .MAX_HOPS (16'hFFFF),
    .PAD_BYTE (8'h00)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en_TX        (en_TX),
    .txPktType    (txPktType),
    .myNodeID     (myNodeID),
    .hopsFromSink (hopsFromSink),
    .myQValue     (myQValue),
    .energy       (energy),
    .e_max        (e_max),
    .e_min        (e_min),
    .e_threshold  (e_threshold),
    .ch_ID        (ch_ID),
    .timeslot     (timeslot),
    .data_in      (data_in),
    .tx_ready     (tx_ready),
    .tx_word      (tx_word),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] t);
    @(posedge clk); #1;
    txPktType = t;
    en_TX     = 1'b1;
    @(posedge clk); #1;
    en_TX     = 1'b0;
  endtask

  // Drives tx_ready, optionally pulses en_TX at cycle pulse_at, records accepted
  // words and checks that stalled words/last stay stable. Stops on done.
  task automatic collect(input bit toggle, input int pulse_at, input int maxcyc);
    logic [15:0] pw;
    logic        pl;
    bit          stalled;
    pw = '0; pl = 1'b0; stalled = 1'b0;
    got_q.delete();
    last_pos  = -1;
    done_seen = 1'b0;
    hold_bad  = 0;
    for (int c = 0; c < maxcyc; c++) begin
      tx_ready = toggle ? c[0] : 1'b1;
      en_TX    = (c == pulse_at);
      @(negedge clk);
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (tx_valid) begin
        if (stalled && (tx_word !== pw || tx_last !== pl)) hold_bad++;
        if (tx_ready) begin
          got_q.push_back(tx_word);
          if (tx_last) last_pos = got_q.size() - 1;
        end
        stalled = !tx_ready;
        pw = tx_word;
        pl = tx_last;
      end
      @(posedge clk); #1;
    end
    en_TX    = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic add_trailer();
`ifdef PKT_CHECKSUM_EN
    logic [15:0] s;
    exp_q[0] = exp_q[0] + 16'd1;
    s = '0;
    foreach (exp_q[i]) s = s + exp_q[i];
    exp_q.push_back(s);
`endif
  endtask

  task automatic check_pkt(input string name);
    logic [15:0] g;
    add_trailer();
    chk({name, " done"}, 32'(done_seen), 32'd1);
    chk({name, " count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hDEAD;
      chk($sformatf("%s w%0d", name, i), 32'(g), 32'(exp_q[i]));
    end
    chk({name, " last_pos"}, last_pos, exp_q.size() - 1);
    chk({name, " hold"}, hold_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; en_TX = 1'b0; txPktType = '0; tx_ready = 1'b1;
    myNodeID = 16'h000C; hopsFromSink = 16'h0001; myQValue = 16'h2000;
    energy = 16'h3000; e_max = 16'h8000; e_min = 16'h4000; e_threshold = 16'h3333;
    ch_ID = 16'h000C; timeslot = 16'h0007; data_in = 16'hA5A5;

    #12;
    chk("reset outs", {tx_valid, tx_last, busy, done, err, tx_word}, '0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // HB, nominal
    start(3'b000);
    chk("hb busy", 32'(busy), 32'd1);
    collect(1'b0, -1, 20);
    exp_q = '{16'h0004, 16'h000C, 16'h0002, 16'h8000, 16'h4000, 16'h3333};
    check_pkt("hb");
    chk("hb done busy", 32'(busy), 32'd0);

    // CHE straight after DONE, toggling ready; inputs change after the strobe
    ch_ID = 16'h000C; myQValue = 16'h2000;
    start(3'b001);
    ch_ID = 16'hBEEF; myQValue = 16'h1111; myNodeID = 16'h7777;
    collect(1'b1, -1, 30);
    exp_q = '{16'h2002, 16'h000C, 16'h000C, 16'h2000};
    check_pkt("che");
    myNodeID = 16'h000C; ch_ID = 16'h000C; myQValue = 16'h2000;

    // invalid type
    @(posedge clk); #1;
    txPktType = 3'b111; en_TX = 1'b1;
    @(posedge clk); #1;
    en_TX = 1'b0;
    chk("inv err", 32'(err), 32'd1);
    chk("inv quiet", {tx_valid, busy}, '0);
    @(posedge clk); #1;
    chk("inv err clr", {err, tx_valid, busy}, '0);

    // HB saturated hop count, en_TX pulsed mid-packet
    hopsFromSink = 16'hFFFF;
    start(3'b000);
    collect(1'b0, 2, 20);
    exp_q = '{16'h0004, 16'h000C, 16'hFFFF, 16'h8000, 16'h4000, 16'h3333};
    check_pkt("hbsat");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hbsat idle%0d", i), {tx_valid, busy, err}, '0);
    end

    // INV
    hopsFromSink = 16'h0005;
    start(3'b010);
    collect(1'b0, -1, 20);
    exp_q = '{16'h4003, 16'h000C, 16'h0005, 16'h2000, 16'h0007};
    check_pkt("inv");

    // DATA aborted by reset after SRC word
    start(3'b100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("data in pay", 32'(tx_valid), 32'd1);
    nrst = 1'b0;
    #1;
    chk("abort outs", {tx_valid, tx_last, busy, done, err, tx_word}, '0);
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort nodone%0d", i), {done, tx_valid}, '0);
    end

    // MR after reset
    ch_ID = 16'h0005; energy = 16'h3000; myQValue = 16'h2000;
    start(3'b011);
    collect(1'b0, -1, 20);
    exp_q = '{16'h6003, 16'h000C, 16'h0005, 16'h3000, 16'h2000};
    check_pkt("mr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
